// File: rtl/spell_mem_arbiter_if.sv
// spell_mem_arbiter_if: requester ports A/B plus the shared memory port, seen from the arbiter (master) or its environment (slave).
interface spell_mem_arbiter_if;
   logic       a_req;
   logic [7:0] a_addr;
   logic       a_done;
   logic [7:0] a_rdata;
   logic       b_req;
   logic [7:0] b_addr;
   logic [7:0] b_wdata;
   logic       b_type_data;
   logic       b_write;
   logic       b_done;
   logic [7:0] b_rdata;
   logic       err;
   logic       mem_select;
   logic [7:0] mem_addr;
   logic [7:0] mem_data_in;
   logic       mem_type_data;
   logic       mem_write;
   logic [7:0] mem_data_out;
   logic       mem_data_ready;
   modport master (
      input  a_req, a_addr, b_req, b_addr, b_wdata, b_type_data, b_write, mem_data_out, mem_data_ready,
      output a_done, a_rdata, b_done, b_rdata, err, mem_select, mem_addr, mem_data_in, mem_type_data, mem_write
   );
   modport slave (
      output a_req, a_addr, b_req, b_addr, b_wdata, b_type_data, b_write, mem_data_out, mem_data_ready,
      input  a_done, a_rdata, b_done, b_rdata, err, mem_select, mem_addr, mem_data_in, mem_type_data, mem_write
   );
endinterface

// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter: shares one memory port between fetch (A) and execute (B) with select/data_ready sequencing and optional timeout.
module spell_mem_arbiter #(
   parameter bit B_PRIORITY = 1'b0,
   parameter int TIMEOUT    = 255
) (
   input logic                clk,
   input logic                rst_n,
   spell_mem_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t     state;
   logic       last_b, gnt_b, pick_b;
   logic [7:0] cnt;
   // tie goes to the port not granted last, or always to B when prioritised
   assign pick_b = bus.b_req & (~bus.a_req | B_PRIORITY | ~last_b);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         last_b            <= 1'b1;
         gnt_b             <= 1'b0;
         cnt               <= '0;
         bus.a_done        <= 1'b0;
         bus.a_rdata       <= '0;
         bus.b_done        <= 1'b0;
         bus.b_rdata       <= '0;
         bus.err           <= 1'b0;
         bus.mem_select    <= 1'b0;
         bus.mem_addr      <= '0;
         bus.mem_data_in   <= '0;
         bus.mem_type_data <= 1'b0;
         bus.mem_write     <= 1'b0;
      end else begin
         bus.a_done <= 1'b0;
         bus.b_done <= 1'b0;
         case (state)
            IDLE: if (bus.a_req || bus.b_req) begin
               gnt_b             <= pick_b;
               last_b            <= pick_b;
               bus.mem_addr      <= pick_b ? bus.b_addr : bus.a_addr;
               bus.mem_data_in   <= pick_b ? bus.b_wdata : 8'h00;
               bus.mem_type_data <= pick_b & bus.b_type_data;
               bus.mem_write     <= pick_b & bus.b_write;
               bus.mem_select    <= 1'b1;
               cnt               <= '0;
               state             <= BUSY;
            end
            BUSY: if (bus.mem_data_ready) begin
               if (gnt_b) begin
                  bus.b_done <= 1'b1;
                  if (!bus.mem_write) bus.b_rdata <= bus.mem_data_out;
               end else begin
                  bus.a_done  <= 1'b1;
                  bus.a_rdata <= bus.mem_data_out;
               end
               bus.err        <= 1'b0;
               bus.mem_select <= 1'b0;
               state          <= RELEASE;
            end else if (TIMEOUT != 0 && cnt == LAST) begin
               if (gnt_b) begin
                  bus.b_done  <= 1'b1;
                  bus.b_rdata <= 8'hff;
               end else begin
                  bus.a_done  <= 1'b1;
                  bus.a_rdata <= 8'hff;
               end
               bus.err        <= 1'b1;
               bus.mem_select <= 1'b0;
               state          <= RELEASE;
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: begin
               bus.err <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb_spell_mem_arbiter: directed requests against a behavioural memory, scoreboard checks every done pulse.
module tb_spell_mem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spell_mem_arbiter_if bus();
   spell_mem_arbiter #(.B_PRIORITY(1'b0), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [7:0] code_m [256];
   logic [7:0] data_m [256];
   int delay = 0;
   bit stall = 1'b0;
   int wcnt = 0;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {bit port_b; logic [7:0] rdata; bit err;} exp_t;
   exp_t sb [$];

   // memory with optional extra latency; data_ready clears when select drops
   always @(posedge clk) begin
      if (!bus.mem_select) begin
         bus.mem_data_ready <= 1'b0;
         wcnt <= 0;
      end else if (!bus.mem_data_ready && !stall) begin
         if (wcnt >= delay) begin
            if (bus.mem_write) begin
               if (bus.mem_type_data) data_m[bus.mem_addr] <= bus.mem_data_in;
               else code_m[bus.mem_addr] <= bus.mem_data_in;
            end else begin
               bus.mem_data_out <= bus.mem_type_data ? data_m[bus.mem_addr] : code_m[bus.mem_addr];
            end
            bus.mem_data_ready <= 1'b1;
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.a_done || bus.b_done) begin
         check("one_done", 32'(bus.a_done & bus.b_done), 0);
         check("sel_low_at_done", 32'(bus.mem_select), 0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: a_done=%0b b_done=%0b with nothing expected", bus.a_done, bus.b_done);
         end else begin
            e = sb.pop_front();
            check("port_b", 32'(bus.b_done), 32'(e.port_b));
            check("rdata", 32'(bus.b_done ? bus.b_rdata : bus.a_rdata), 32'(e.rdata));
            check("err", 32'(bus.err), 32'(e.err));
         end
      end else if (rst_n) begin
         check("err_idle", 32'(bus.err), 0);
      end
   end

   task automatic wait_done(input bit port_b, output int at);
      at = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (port_b ? bus.b_done : bus.a_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: port_b=%0b got no done want done within 50 cycles", port_b);
      end
   endtask

   task automatic fetch(input logic [7:0] addr, input logic [7:0] exp, output int k, output int at);
      @(negedge clk);
      bus.a_req = 1'b1;
      bus.a_addr = addr;
      sb.push_back('{1'b0, exp, 1'b0});
      k = cyc + 1;
      wait_done(1'b0, at);
      bus.a_req = 1'b0;
   endtask

   task automatic bop(input logic [7:0] addr, input logic [7:0] wd, input bit ty, input bit wr,
                      input logic [7:0] exp, input bit e_err, output int k, output int at);
      @(negedge clk);
      bus.b_req = 1'b1;
      bus.b_addr = addr;
      bus.b_wdata = wd;
      bus.b_type_data = ty;
      bus.b_write = wr;
      sb.push_back('{1'b1, exp, e_err});
      k = cyc + 1;
      wait_done(1'b1, at);
      bus.b_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, at, t0, t1, t2, t3;
      for (int i = 0; i < 256; i++) begin
         code_m[i] = 8'h00;
         data_m[i] = 8'h00;
      end
      code_m[8'h10] = 8'h5A;
      data_m[8'h40] = 8'h77;
      bus.mem_data_out = 8'h00;
      bus.mem_data_ready = 1'b0;
      // 1: reset with both requests pending, then A wins first tie
      bus.a_req = 1'b1; bus.a_addr = 8'h10;
      bus.b_req = 1'b1; bus.b_addr = 8'h40; bus.b_wdata = 8'h00; bus.b_type_data = 1'b1; bus.b_write = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_select", 32'(bus.mem_select), 0);
      check("rst_a_done", 32'(bus.a_done), 0);
      check("rst_b_done", 32'(bus.b_done), 0);
      check("rst_err", 32'(bus.err), 0);
      sb.push_back('{1'b0, 8'h5A, 1'b0});
      sb.push_back('{1'b1, 8'h77, 1'b0});
      rst_n = 1'b1;
      wait_done(1'b0, at);
      wait_done(1'b1, at);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      // 2: single fetch latency
      fetch(8'h10, 8'h5A, k, at);
      check("fetch_latency", 32'(at - k), 2);
      // 3: write keeps b_rdata, then read back
      bop(8'h04, 8'h33, 1'b1, 1'b1, 8'h77, 1'b0, k, at);
      bop(8'h04, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, k, at);
      // 4: contention alternates A,B,A,B every 4 cycles
      @(negedge clk);
      bus.a_req = 1'b1; bus.a_addr = 8'h10;
      bus.b_req = 1'b1; bus.b_addr = 8'h04; bus.b_type_data = 1'b1; bus.b_write = 1'b0;
      sb.push_back('{1'b0, 8'h5A, 1'b0});
      sb.push_back('{1'b1, 8'h33, 1'b0});
      sb.push_back('{1'b0, 8'h5A, 1'b0});
      sb.push_back('{1'b1, 8'h33, 1'b0});
      wait_done(1'b0, t0);
      wait_done(1'b1, t1);
      wait_done(1'b0, t2);
      wait_done(1'b1, t3);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      check("rr_gap0", 32'(t1 - t0), 4);
      check("rr_gap1", 32'(t2 - t1), 4);
      check("rr_gap2", 32'(t3 - t2), 4);
      // 5: timeout after 8 busy cycles, then normal service
      stall = 1'b1;
      bop(8'h40, 8'h00, 1'b1, 1'b0, 8'hff, 1'b1, k, at);
      check("timeout_latency", 32'(at - k), 8);
      stall = 1'b0;
      bop(8'h40, 8'h00, 1'b1, 1'b0, 8'h77, 1'b0, k, at);
      // 6: reset while busy abandons the transaction
      delay = 5;
      @(negedge clk);
      bus.b_req = 1'b1; bus.b_addr = 8'h04; bus.b_type_data = 1'b1; bus.b_write = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_select", 32'(bus.mem_select), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_select", 32'(bus.mem_select), 0);
      check("abort_b_done", 32'(bus.b_done), 0);
      bus.b_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      delay = 0;
      bop(8'h04, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, k, at);
      check("post_reset_latency", 32'(at - k), 2);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
